ram_bist_seq: RTL and testbench

- Upstream controller for the 256x8 single-port RAM IP.
- Drives address, write data, wren and rden for the RAM. Consumes its q output.
- On a start request it fills the RAM with an arithmetic pattern, reads every word back, and compares each word against the expected value.
- Reports busy/done/pass, an error count and the first failing address. These are intended for board LEDs.

---
 rtl/ram_bist_seq_pkg.sv | 21 ++
 rtl/ram_bist_cmp_pipe.sv | 77 +++++++
 rtl/ram_bist_seq.sv | 125 ++++++++++++
 tb/tb_ram_bist_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_seq_pkg.sv
// Shared types and helpers for the RAM BIST sequencer: FSM states, default widths and
// the arithmetic fill pattern.
package ram_bist_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    // Full-width product; callers truncate to their data width, which gives the mod 2**DATA_W.
    function automatic logic [31:0] expected(input logic [31:0] addr, input int unsigned step);
        return addr * step;
    endfunction

endpackage

// File: rtl/ram_bist_cmp_pipe.sv
// Read-compare pipeline: delays {valid, expected, addr} by the RAM read latency and keeps
// a saturating mismatch count plus the address of the first mismatch of the run.
module ram_bist_cmp_pipe #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              kill,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_exp,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]     exp_q  [RD_LATENCY];
    logic [ADDR_W-1:0]     addr_q [RD_LATENCY];
    logic [7:0]            err_count_q, err_count_d;
    logic [ADDR_W-1:0]     first_err_q, first_err_d;
    logic                  mismatch;

    always_ff @(posedge clk) begin
        if (kill) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                exp_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= push;
            exp_q[0]  <= push_exp;
            addr_q[0] <= push_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    // The tail lines up with ram_q for the read issued RD_LATENCY cycles earlier.
    assign mismatch = vld_q[RD_LATENCY-1] && (ram_q != exp_q[RD_LATENCY-1]);

    always_comb begin
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        if (clear) begin
            err_count_d = '0;
            first_err_d = '0;
        end else if (mismatch) begin
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
            if (err_count_q == 8'd0) begin
                first_err_d = addr_q[RD_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            err_count_q <= '0;
            first_err_q <= '0;
        end else begin
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;

endmodule

// File: rtl/ram_bist_seq.sv
// RAM BIST sequencer: on a start edge writes an arithmetic pattern to every word, reads it
// all back and reports pass/fail, mismatch count and first failing address.
module ram_bist_seq
    import ram_bist_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DATA_STEP  = 10,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              kill,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [2:0]        drain_q, drain_d;
    logic              start_q;
    logic              run_start;
    logic              cnt_last;
    logic              push;
    logic [DATA_W-1:0] pat;

    // Start is a level from a key; only a fresh rising edge in IDLE/DONE launches a run.
    assign run_start = start && !start_q && (state_q == StIdle || state_q == StDone);
    assign cnt_last  = &cnt_q;
    assign pat       = DATA_W'(expected(32'(cnt_q), DATA_STEP));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        ram_rden = 1'b0;
        push     = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (run_start) begin
                    state_d = StWrite;
                    cnt_d   = '0;
                end
            end
            StWrite: begin
                ram_wren = 1'b1;
                ram_addr = cnt_q;
                ram_data = pat;
                if (cnt_last) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRead: begin
                ram_rden = 1'b1;
                ram_addr = cnt_q;
                push     = 1'b1;
                if (cnt_last) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == 3'(RD_LATENCY - 1)) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            drain_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            start_q <= start;
        end
    end

    ram_bist_cmp_pipe #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_LATENCY(RD_LATENCY)
    ) u_cmp_pipe (
        .clk           (clk),
        .kill          (kill),
        .clear         (run_start),
        .push          (push),
        .push_exp      (pat),
        .push_addr     (cnt_q),
        .ram_q         (ram_q),
        .err_count     (err_count),
        .first_err_addr(first_err_addr)
    );

    assign busy = (state_q == StWrite) || (state_q == StRead) || (state_q == StDrain);
    assign done = (state_q == StDone);
    // Last compare lands on the same edge that enters DONE, so the count is final here.
    assign pass = done && (err_count == 8'd0);

endmodule

// File: tb/tb_ram_bist_seq.sv
// Bench for ram_bist_seq: two instances (2-cycle and 1-cycle RAM models), a result
// scoreboard popped on each done rise, and a cycle-tagged bus checkpoint queue.
module tb_ram_bist_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      start, kill;
    logic [1:0][7:0] ram_addr, ram_data, ram_q, err_count, first_err_addr;
    logic [1:0]      ram_wren, ram_rden, busy, done, pass;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int fault_mode = 0;
    bit mon_en     = 1'b0;

    typedef struct {int dut; int err; int fea; int ps; int cyc;} result_t;
    typedef struct {int cyc; int wren; int addr; int data; int err; int busy; int done;} bus_t;
    result_t res_q[$];
    bus_t    bus_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input logic [7:0] a);
        return 8'((int'(a) * 10) % 256);
    endfunction

    function automatic logic [7:0] corrupt(input logic [7:0] d, input logic [7:0] a);
        if (fault_mode == 1 && (a == 8'h80 || a == 8'hC3)) return d ^ 8'h01;
        if (fault_mode == 2) return ~d;
        return d;
    endfunction

    ram_bist_seq #(.RD_LATENCY(2)) u_dut0 (
        .clk(clk), .kill(kill[0]), .start(start[0]),
        .ram_addr(ram_addr[0]), .ram_data(ram_data[0]), .ram_wren(ram_wren[0]),
        .ram_rden(ram_rden[0]), .ram_q(ram_q[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err_count[0]), .first_err_addr(first_err_addr[0])
    );

    ram_bist_seq #(.RD_LATENCY(1)) u_dut1 (
        .clk(clk), .kill(kill[1]), .start(start[1]),
        .ram_addr(ram_addr[1]), .ram_data(ram_data[1]), .ram_wren(ram_wren[1]),
        .ram_rden(ram_rden[1]), .ram_q(ram_q[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err_count[1]), .first_err_addr(first_err_addr[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_ram
        logic [7:0] mem [256];
        logic [7:0] s1, s2;
        bit         done_prev = 1'b0;

        always @(posedge clk) begin
            if (ram_wren[g]) mem[ram_addr[g]] <= ram_data[g];
            s1 <= ram_rden[g] ? corrupt(mem[ram_addr[g]], ram_addr[g]) : 8'h00;
            s2 <= s1;
        end
        assign ram_q[g] = (g == 0) ? s2 : s1;

        always @(negedge clk) begin
            result_t r;
            if (mon_en) begin
                n_checks++;
                if (ram_wren[g] && ram_rden[g]) begin
                    n_fail++;
                    $display("FAIL wren_rden_overlap dut%0d cycle %0d", g, cyc);
                end else if (ram_wren[g] && ram_data[g] != pat(ram_addr[g])) begin
                    n_fail++;
                    $display("FAIL write_pattern dut%0d addr %0d: got %0d, expected %0d",
                             g, ram_addr[g], ram_data[g], pat(ram_addr[g]));
                end else if (!ram_wren[g] && ram_data[g] != 8'h00) begin
                    n_fail++;
                    $display("FAIL data_not_zero dut%0d: got %0d, expected 0", g, ram_data[g]);
                end else if (!ram_wren[g] && !ram_rden[g] && ram_addr[g] != 8'h00) begin
                    n_fail++;
                    $display("FAIL idle_addr dut%0d: got %0d, expected 0", g, ram_addr[g]);
                end
                if (done[g] && !done_prev) begin
                    if (res_q.size() == 0) begin
                        chk("unexpected_done_queue_size", 0, 1);
                    end else begin
                        r = res_q.pop_front();
                        chk("done_dut", g, r.dut);
                        chk("done_cycle", cyc, r.cyc);
                        chk("err_count", int'(err_count[g]), r.err);
                        chk("first_err_addr", int'(first_err_addr[g]), r.fea);
                        chk("pass", int'(pass[g]), r.ps);
                        chk("busy_at_done", int'(busy[g]), 0);
                    end
                end
                done_prev <= done[g];
            end
        end
    end

    always @(negedge clk) begin
        bus_t b;
        if (mon_en && bus_q.size() > 0 && cyc >= bus_q[0].cyc) begin
            b = bus_q.pop_front();
            chk("bus_cycle", cyc, b.cyc);
            chk("bus_wren", int'(ram_wren[0]), b.wren);
            chk("bus_addr", int'(ram_addr[0]), b.addr);
            chk("bus_data", int'(ram_data[0]), b.data);
            chk("bus_err_count", int'(err_count[0]), b.err);
            chk("bus_busy", int'(busy[0]), b.busy);
            chk("bus_done", int'(done[0]), b.done);
        end
    end

    task automatic run(input int g, input int mode, input int e_err, input int e_fea,
                       input int e_ps, input bit hold);
        int n;
        bit got;
        fault_mode = mode;
        @(posedge clk);
        #1;
        start[g] = 1'b1;
        n = cyc;
        res_q.push_back('{g, e_err, e_fea, e_ps, n + ((g == 0) ? 515 : 514)});
        if (g == 0) begin
            bus_q.push_back('{n + 1, 1, 0, 0, 0, 1, 0});
            bus_q.push_back('{n + 6, 1, 5, 50, 0, 1, 0});
            bus_q.push_back('{n + 27, 1, 26, 4, 0, 1, 0});
        end
        @(posedge clk);
        #1;
        if (!hold) start[g] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (done[g]) begin
                got = 1'b1;
                break;
            end
        end
        chk("run_completes", int'(got), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        start = 2'b00;
        kill  = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy", int'(busy[g]), 0);
            chk("rst_done", int'(done[g]), 0);
            chk("rst_pass", int'(pass[g]), 0);
            chk("rst_err_count", int'(err_count[g]), 0);
            chk("rst_first_err_addr", int'(first_err_addr[g]), 0);
            chk("rst_wren", int'(ram_wren[g]), 0);
            chk("rst_rden", int'(ram_rden[g]), 0);
            chk("rst_addr", int'(ram_addr[g]), 0);
            chk("rst_data", int'(ram_data[g]), 0);
        end
        @(posedge clk);
        #1;
        kill   = 2'b00;
        mon_en = 1'b1;

        run(0, 0, 0, 0, 1, 1'b0);
        run(0, 1, 2, 8'h80, 0, 1'b0);
        run(0, 2, 255, 0, 0, 1'b1);

        // Start still held: DONE must persist with no restart.
        repeat (20) begin
            @(negedge clk);
            chk("hold_done", int'(done[0]), 1);
            chk("hold_busy", int'(busy[0]), 0);
        end
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        run(0, 0, 0, 0, 1, 1'b0);

        // Kill while the 100th write (addr 99) is on the bus.
        fault_mode = 0;
        @(posedge clk);
        #1;
        start[0] = 1'b1;
        n = cyc;
        bus_q.push_back('{n + 1, 1, 0, 0, 0, 1, 0});
        bus_q.push_back('{n + 100, 1, 99, 222, 0, 1, 0});
        bus_q.push_back('{n + 101, 0, 0, 0, 0, 0, 0});
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        while (cyc != n + 100) begin
            @(posedge clk);
            #1;
        end
        kill[0] = 1'b1;
        @(posedge clk);
        #1;
        kill[0] = 1'b0;
        @(negedge clk);
        chk("kill_done", int'(done[0]), 0);
        chk("kill_rden", int'(ram_rden[0]), 0);
        chk("kill_first_err_addr", int'(first_err_addr[0]), 0);
        run(0, 0, 0, 0, 1, 1'b0);

        run(1, 0, 0, 0, 1, 1'b0);

        repeat (5) @(posedge clk);
        chk("result_queue_drained", res_q.size(), 0);
        chk("bus_queue_drained", bus_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
